// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and constants for the pipeline stall/flush scheduler.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RUN  = 2'b00,
        S_WAIT = 2'b01
    } state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam logic [4:0]  REG_ZERO = 5'd0;
    localparam int          WCNT_W   = 4;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detection: the EX load writes a register the ID instruction reads.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rt,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    output logic       lu
);

    // r0 is hardwired to zero, so a load targeting it never creates a dependency
    always_comb begin
        lu = ex_memread && (ex_rt != REG_ZERO) &&
             ((ex_rt == id_rs) || (id_use_rt && (ex_rt == id_rt)));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_RUN  | fetch word available this cycle; pipeline may advance
// S_WAIT | instruction fetch outstanding; wcnt cycles remain
// 2'b1x  | illegal; all controls idle, returns to S_RUN next cycle
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int IMEM_WAIT = 0,
    parameter int CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rt,
    input  logic             id_jump,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch,
    input  logic             ex_zero,
    output logic             stall,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam bit                HAS_WAIT = (IMEM_WAIT > 0);
    localparam logic [WCNT_W-1:0] WAIT_LD  = WCNT_W'(IMEM_WAIT);
    localparam state_t            RST_ST   = HAS_WAIT ? S_WAIT : S_RUN;

    state_t            state, state_nxt;
    logic [WCNT_W-1:0] wcnt, wcnt_nxt;
    logic              br_taken;
    logic              lu;
    logic              restart;
    logic              stall_i, hold_i, flush_i, bubble_i;

    hazard_detect u_hazard (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_rt  (id_use_rt),
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .lu         (lu)
    );

    assign br_taken   = ex_branch & ex_zero;
    assign ctrl_state = state;

    // Next-state, wait-count and raw control decode; priority br > lu > jump > wait
    always_comb begin
        stall_i   = 1'b0;
        hold_i    = 1'b0;
        flush_i   = 1'b0;
        bubble_i  = 1'b0;
        restart   = 1'b0;
        state_nxt = S_RUN;
        wcnt_nxt  = wcnt;
        case (state)
            S_RUN: begin
                if (br_taken) begin
                    flush_i  = 1'b1;
                    bubble_i = 1'b1;
                    restart  = 1'b1;
                end else if (lu) begin
                    // fetched word is kept in IF/ID, so no new fetch starts
                    stall_i  = 1'b1;
                    hold_i   = 1'b1;
                    bubble_i = 1'b1;
                end else if (id_jump) begin
                    flush_i  = 1'b1;
                    restart  = 1'b1;
                end else begin
                    restart  = 1'b1;
                end
                if (restart && HAS_WAIT) begin
                    state_nxt = S_WAIT;
                    wcnt_nxt  = WAIT_LD;
                end
            end
            S_WAIT: begin
                stall_i   = 1'b1;
                flush_i   = 1'b1;
                state_nxt = S_WAIT;
                if (br_taken) begin
                    // fetch restarts at the branch target
                    bubble_i = 1'b1;
                    wcnt_nxt = WAIT_LD;
                end else if (id_jump && !lu) begin
                    wcnt_nxt = WAIT_LD;
                end else begin
                    if (lu) begin
                        // only case where hold beats flush: the ID instruction must survive
                        hold_i   = 1'b1;
                        flush_i  = 1'b0;
                        bubble_i = 1'b1;
                    end
                    wcnt_nxt = wcnt - 1'b1;
                    if (wcnt <= WCNT_W'(1)) begin
                        state_nxt = S_RUN;
                    end
                end
            end
            default: begin
                state_nxt = S_RUN;
            end
        endcase
    end

    // Reset forces a safe pipeline: PC held, IF/ID and ID/EX loaded with NOPs
    always_comb begin
        if (Reset) begin
            stall       = 1'b1;
            ifid_hold   = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            stall       = stall_i;
            ifid_hold   = hold_i;
            ifid_flush  = flush_i;
            idex_bubble = bubble_i;
        end
    end

    // FSM state and fetch wait counter
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= RST_ST;
            wcnt  <= WAIT_LD;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            stall_cnt <= '0;
        end else if (stall_i && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized and directed checks of pipe_ctrl against a fetch-countdown reference model.
module tb_pipe_ctrl;

    logic       CLK;
    logic       Reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_use_rt, id_jump, ex_memread, ex_branch, ex_zero;

    logic        stall0, hold0, flush0, bubble0;
    logic [1:0]  state0;
    logic [3:0]  cnt0;
    logic        stall3, hold3, flush3, bubble3;
    logic [1:0]  state3;
    logic [15:0] cnt3;

    logic [21:0] obs0, obs3;
    assign obs0 = {stall0, hold0, flush0, bubble0, state0, 12'd0, cnt0};
    assign obs3 = {stall3, hold3, flush3, bubble3, state3, cnt3};

    int vectors = 0;
    int errors  = 0;

    // model: fetch_left = cycles until the outstanding fetch completes (0 = running)
    int fl[2];
    int cnt[2];
    int nfl[2];
    int ncnt[2];
    int wait_cfg[2] = '{0, 3};
    int cnt_max[2]  = '{15, 65535};

    pipe_ctrl #(.IMEM_WAIT(0), .CNT_W(4)) dut0 (
        .CLK(CLK), .Reset(Reset), .id_rs(id_rs), .id_rt(id_rt), .id_use_rt(id_use_rt),
        .id_jump(id_jump), .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch(ex_branch),
        .ex_zero(ex_zero), .stall(stall0), .ifid_hold(hold0), .ifid_flush(flush0),
        .idex_bubble(bubble0), .ctrl_state(state0), .stall_cnt(cnt0)
    );

    pipe_ctrl #(.IMEM_WAIT(3), .CNT_W(16)) dut3 (
        .CLK(CLK), .Reset(Reset), .id_rs(id_rs), .id_rt(id_rt), .id_use_rt(id_use_rt),
        .id_jump(id_jump), .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch(ex_branch),
        .ex_zero(ex_zero), .stall(stall3), .ifid_hold(hold3), .ifid_flush(flush3),
        .idex_bubble(bubble3), .ctrl_state(state3), .stall_cnt(cnt3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_use_rt = 1'b0; id_jump = 1'b0;
        ex_memread = 1'b0; ex_rt = 5'd0; ex_branch = 1'b0; ex_zero = 1'b0;
    endtask

    task automatic model_cycle(input int i, output logic [21:0] e);
        logic s, h, f, b;
        bit br, lu;
        br = ex_branch && ex_zero;
        lu = ex_memread && (ex_rt != 5'd0) &&
             ((ex_rt == id_rs) || (id_use_rt && (ex_rt == id_rt)));
        s = 0; h = 0; f = 0; b = 0;
        nfl[i] = fl[i];
        if (fl[i] == 0) begin
            if (br) begin f = 1; b = 1; nfl[i] = wait_cfg[i]; end
            else if (lu) begin s = 1; h = 1; b = 1; end
            else if (id_jump) begin f = 1; nfl[i] = wait_cfg[i]; end
            else nfl[i] = wait_cfg[i];
        end else begin
            s = 1; f = 1;
            if (br) begin b = 1; nfl[i] = wait_cfg[i]; end
            else if (lu) begin h = 1; f = 0; b = 1; nfl[i] = fl[i] - 1; end
            else if (id_jump) nfl[i] = wait_cfg[i];
            else nfl[i] = fl[i] - 1;
        end
        ncnt[i] = (s && cnt[i] < cnt_max[i]) ? cnt[i] + 1 : cnt[i];
        e = {s, h, f, b, (fl[i] > 0) ? 2'b01 : 2'b00, 16'(cnt[i])};
    endtask

    task automatic commit();
        for (int i = 0; i < 2; i++) begin
            fl[i]  = nfl[i];
            cnt[i] = ncnt[i];
        end
    endtask

    // asserts Reset mid-cycle across one rising edge, releases mid-cycle
    task automatic do_reset();
        #1 Reset = 1'b1;
        @(posedge CLK);
        #2 Reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            fl[i]  = wait_cfg[i];
            cnt[i] = 0;
        end
    endtask

    task automatic test_reset();
        logic [21:0] e0, e1;
        idle();
        #1 Reset = 1'b1;
        #2;
        vectors++;
        if (obs0 !== {4'b1011, 2'b00, 16'd0}) begin
            errors++; $display("FAIL reset_hold_w0 got %h expected %h", obs0, {4'b1011, 2'b00, 16'd0});
        end
        vectors++;
        if (obs3 !== {4'b1011, 2'b01, 16'd0}) begin
            errors++; $display("FAIL reset_hold_w3 got %h expected %h", obs3, {4'b1011, 2'b01, 16'd0});
        end
        @(posedge CLK);
        #2 Reset = 1'b0;
        for (int i = 0; i < 2; i++) begin fl[i] = wait_cfg[i]; cnt[i] = 0; end
        for (int k = 0; k < 4; k++) begin
            #4;
            vectors++;
            if ({stall0, hold0, flush0, bubble0, state0, cnt0} !== 10'd0) begin
                errors++; $display("FAIL reset_idle_w0 got %h expected 0", {stall0, hold0, flush0, bubble0, state0, cnt0});
            end
            model_cycle(0, e0); model_cycle(1, e1);
            vectors++;
            if (obs3 !== e1) begin errors++; $display("FAIL reset_idle_w3 got %h expected %h", obs3, e1); end
            @(posedge CLK); commit(); #1;
        end
    endtask

    task automatic test_load_use();
        logic [21:0] e0, e1;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            idle();
            if (k == 0) begin ex_memread = 1; ex_rt = 5'd8; id_rs = 5'd8; end
            if (k == 2) begin ex_memread = 1; ex_rt = 5'd0; id_rs = 5'd0; end
            #4;
            model_cycle(0, e0); model_cycle(1, e1);
            vectors++;
            if (obs0 !== e0) begin errors++; $display("FAIL load_use_w0 cyc %0d got %h expected %h", k, obs0, e0); end
            vectors++;
            if (obs3 !== e1) begin errors++; $display("FAIL load_use_w3 cyc %0d got %h expected %h", k, obs3, e1); end
            if (k == 0) begin
                vectors++;
                if ({stall0, hold0, bubble0} !== 3'b111) begin
                    errors++; $display("FAIL lu_controls got %b expected 111", {stall0, hold0, bubble0});
                end
            end
            if (k == 1) begin
                vectors++;
                if (cnt0 !== 4'd1) begin errors++; $display("FAIL lu_stall_cnt got %0d expected 1", cnt0); end
            end
            if (k == 2) begin
                vectors++;
                if (stall0 !== 1'b0) begin errors++; $display("FAIL lu_r0_nostall got %b expected 0", stall0); end
            end
            @(posedge CLK); commit(); #1;
        end
    endtask

    task automatic test_priority();
        logic [21:0] e0, e1;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            idle();
            if (k == 0) begin
                ex_memread = 1; ex_rt = 5'd8; id_rs = 5'd8; ex_branch = 1; ex_zero = 1; id_jump = 1;
            end
            #4;
            model_cycle(0, e0); model_cycle(1, e1);
            vectors++;
            if (obs0 !== e0) begin errors++; $display("FAIL priority_w0 cyc %0d got %h expected %h", k, obs0, e0); end
            vectors++;
            if (obs3 !== e1) begin errors++; $display("FAIL priority_w3 cyc %0d got %h expected %h", k, obs3, e1); end
            if (k == 0) begin
                vectors++;
                if ({stall0, hold0, flush0, bubble0} !== 4'b0011) begin
                    errors++; $display("FAIL br_over_lu got %b expected 0011", {stall0, hold0, flush0, bubble0});
                end
            end
            @(posedge CLK); commit(); #1;
        end
    endtask

    task automatic test_wait_period();
        logic [21:0] e0, e1;
        do_reset();
        idle();
        for (int k = 0; k < 12; k++) begin
            #4;
            model_cycle(0, e0); model_cycle(1, e1);
            vectors++;
            if (obs3 !== e1) begin errors++; $display("FAIL wait_period_w3 cyc %0d got %h expected %h", k, obs3, e1); end
            vectors++;
            if ({stall3, flush3} !== ((k % 4 != 3) ? 2'b11 : 2'b00)) begin
                errors++; $display("FAIL wait_pattern cyc %0d got %b expected %b", k, {stall3, flush3}, (k % 4 != 3) ? 2'b11 : 2'b00);
            end
            @(posedge CLK); commit(); #1;
        end
    endtask

    task automatic test_branch_reload();
        logic [21:0] e0, e1;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            idle();
            if (k == 2) begin ex_branch = 1; ex_zero = 1; end
            #4;
            model_cycle(0, e0); model_cycle(1, e1);
            vectors++;
            if (obs3 !== e1) begin errors++; $display("FAIL br_reload_w3 cyc %0d got %h expected %h", k, obs3, e1); end
            vectors++;
            if (obs0 !== e0) begin errors++; $display("FAIL br_reload_w0 cyc %0d got %h expected %h", k, obs0, e0); end
            if (k >= 3 && k <= 6) begin
                vectors++;
                if (stall3 !== (k != 6)) begin
                    errors++; $display("FAIL br_reload_stall cyc %0d got %b expected %b", k, stall3, k != 6);
                end
            end
            @(posedge CLK); commit(); #1;
        end
        // dut3 is now at wcnt=2; reset mid-fetch
        do_reset();
        #1;
        vectors++;
        if ({state3, cnt3} !== {2'b01, 16'd0}) begin
            errors++; $display("FAIL reset_mid_wait got %h expected %h", {state3, cnt3}, {2'b01, 16'd0});
        end
        idle();
        for (int k = 0; k < 5; k++) begin
            #4;
            model_cycle(0, e0); model_cycle(1, e1);
            vectors++;
            if (obs3 !== e1) begin errors++; $display("FAIL after_reset_w3 cyc %0d got %h expected %h", k, obs3, e1); end
            @(posedge CLK); commit(); #1;
        end
    endtask

    task automatic test_saturation();
        logic [21:0] e0, e1;
        do_reset();
        idle();
        ex_memread = 1; ex_rt = 5'd8; id_rs = 5'd8;
        for (int k = 0; k < 21; k++) begin
            #4;
            model_cycle(0, e0); model_cycle(1, e1);
            vectors++;
            if (obs0 !== e0) begin errors++; $display("FAIL saturate_w0 cyc %0d got %h expected %h", k, obs0, e0); end
            vectors++;
            if (obs3 !== e1) begin errors++; $display("FAIL saturate_w3 cyc %0d got %h expected %h", k, obs3, e1); end
            @(posedge CLK); commit(); #1;
        end
        vectors++;
        if (cnt0 !== 4'd15) begin errors++; $display("FAIL stall_cnt_sat got %0d expected 15", cnt0); end
    endtask

    task automatic test_random();
        logic [21:0] e0, e1;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            id_rs      = 5'($urandom_range(0, 3));
            id_rt      = 5'($urandom_range(0, 3));
            ex_rt      = 5'($urandom_range(0, 3));
            id_use_rt  = 1'($urandom_range(0, 1));
            ex_memread = 1'($urandom_range(0, 1));
            ex_branch  = ($urandom_range(0, 3) == 0);
            ex_zero    = 1'($urandom_range(0, 1));
            id_jump    = ($urandom_range(0, 6) == 0);
            #4;
            model_cycle(0, e0); model_cycle(1, e1);
            vectors++;
            if (obs0 !== e0) begin errors++; $display("FAIL random_w0 cyc %0d got %h expected %h", k, obs0, e0); end
            vectors++;
            if (obs3 !== e1) begin errors++; $display("FAIL random_w3 cyc %0d got %h expected %h", k, obs3, e1); end
            @(posedge CLK); commit(); #1;
        end
    endtask

    initial begin
        Reset = 1'b1;
        idle();
        @(posedge CLK);
        #1;
        test_reset();
        test_load_use();
        test_priority();
        test_wait_period();
        test_branch_reload();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage pipeline.
- Drives the fetch stage `stall` input and the IF/ID and ID/EX pipeline-register controls.
- Sequences instruction-memory wait states, load-use bubbles, jump flushes and taken-branch flushes.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- IMEM_WAIT, 0, extra wait cycles per instruction fetch (0..15).
- CNT_W, 16, width of stall performance counter.

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- id_rs  in  5  rs field of instruction in ID.
- id_rt  in  5  rt field of instruction in ID.
- id_use_rt  in  1  ID instruction reads rt as a source.
- id_jump  in  1  ID instruction is a jump.
- ex_memread  in  1  EX instruction is a load.
- ex_rt  in  5  destination register of EX load.
- ex_branch  in  1  EX instruction is a branch.
- ex_zero  in  1  ALU zero for EX branch.
- stall  out  1  hold PC (to fetch stage).
- ifid_hold  out  1  IF/ID register keeps its contents.
- ifid_flush  out  1  IF/ID register loads NOP (0x00000000).
- idex_bubble  out  1  ID/EX register loads NOP/control-zero.
- ctrl_state  out  2  current FSM state (debug).
- stall_cnt  out  CNT_W  stall cycles since reset, saturating.

Behaviour:
- All control outputs are combinational from FSM state, wait counter and current inputs; they act on the same cycle.
- stall_cnt and the FSM/counter are registered.
- Reset (any time, including mid-wait):
  - state=S_WAIT if IMEM_WAIT>0, else S_RUN.
  - wcnt=IMEM_WAIT; stall_cnt=0.
  - During Reset, stall=1, ifid_flush=1, idex_bubble=1, ifid_hold=0.
- Events:
  - br_taken = ex_branch & ex_zero.
  - lu = ex_memread & (ex_rt!=0) & ((ex_rt==id_rs) | (id_use_rt & ex_rt==id_rt)).
- Priority, highest first: br_taken > lu > id_jump > wait.
- S_RUN (fetch complete this cycle):
  - br_taken: ifid_flush=1, idex_bubble=1, stall=0 (PC takes target). Next state: S_WAIT with wcnt=IMEM_WAIT, or S_RUN if IMEM_WAIT=0.
  - else lu: stall=1, ifid_hold=1, idex_bubble=1. Stay S_RUN; wcnt unchanged (fetched word retained).
  - else id_jump: ifid_flush=1, stall=0. Next state as for the br_taken case.
  - else: all controls 0. If IMEM_WAIT>0, go to S_WAIT with wcnt=IMEM_WAIT (the next fetch starts).
- S_WAIT (fetch outstanding):
  - Default: stall=1, ifid_flush=1 (ID receives NOP), idex_bubble=0 (ID instruction advances).
  - wcnt decrements each cycle. On wcnt==1, next state is S_RUN.
  - br_taken: idex_bubble=1; wcnt reloads IMEM_WAIT (fetch restarts at target). Stall remains 1, but PC load of target is permitted; the fetch stage gives branch-target load precedence over stall.
  - lu: ifid_hold=1, ifid_flush=0, idex_bubble=1; wcnt still decrements.
  - id_jump: ifid_flush=1; wcnt reloads IMEM_WAIT.
- IMEM_WAIT=0: S_WAIT is unreachable; state stays S_RUN.
- Never assert ifid_hold and ifid_flush together; flush wins except for the lu case in S_WAIT.
- stall_cnt increments on every cycle where stall=1 and Reset=0; it holds at all-ones.
- Encoding: S_RUN=2'b00, S_WAIT=2'b01; 2'b1x are illegal and return to S_RUN next cycle.

Decomposition:
- Shared package holds:
  - state encodings S_RUN and S_WAIT;
  - NOP_INST=32'h0000_0000;
  - REG_ZERO=5'd0.
- One sub-module, hazard_detect: purely combinational, produces lu from the id_*/ex_* fields. The FSM, wait counter and perf counter stay in pipe_ctrl.

Test Plan:
- IMEM_WAIT=0; Reset pulse mid-cycle, then idle inputs -> all controls 0 after release; stall_cnt=0; ctrl_state=00.
- IMEM_WAIT=0; ex_memread=1, ex_rt=5'd8, id_rs=5'd8 for 1 cycle -> stall=ifid_hold=idex_bubble=1 that cycle; stall_cnt=1. Repeat with ex_rt=0 -> no stall.
- IMEM_WAIT=0; lu and br_taken in the same cycle -> ifid_flush=1, idex_bubble=1, stall=0, ifid_hold=0.
- IMEM_WAIT=3; after reset release -> stall=1 for exactly 3 cycles with ifid_flush=1, then one S_RUN cycle; repeats every 4 cycles.
- IMEM_WAIT=3; br_taken while wcnt=1 -> wcnt reloads to 3; stall=1 for 3 further cycles; Reset asserted at wcnt=2 -> wcnt=3, stall_cnt=0.
- IMEM_WAIT=0; force stall=1 for 2^CNT_W+5 cycles via persistent lu with CNT_W=4 -> stall_cnt saturates at 15.
